// File: rtl/msg_ctrl_pkg.sv
// Shared types and constants for the message dispatch controller.
package msg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_DISPATCH = 3'd2,
    ST_DROP     = 3'd3,
    ST_HOLDOFF  = 3'd4
  } state_t;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 7;

  typedef enum logic [7:0] {
    OP_NONE    = 8'd0,
    OP_ENCRYPT = 8'd1,
    OP_DECRYPT = 8'd2
  } opcode_t;

endpackage

// File: rtl/dispatch_timer.sv
// Dispatch watchdog: cleared on load, counts while enabled, flags the final cycle.
module dispatch_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic load_in,
  input  logic enable_in,
  output logic expire_out
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Cycle counter for the time a frame spends waiting in DISPATCH
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count <= '0;
    end else if (load_in) begin
      count <= '0;
    end else if (enable_in) begin
      count <= count + CNT_W'(1);
    end
  end

  // Expiry is combinational so the FSM can drop the frame on the last counted cycle
  assign expire_out = enable_in && (count == LAST);

endmodule

// File: rtl/msg_dispatch_ctrl.sv
// Routes bridge frames to engines by header opcode, with busy tracking,
// dispatch timeout, illegal-opcode drop, and dispatch/drop counters.
module msg_dispatch_ctrl
  import msg_ctrl_pkg::*;
#(
  parameter int MESSAGE_SIZE   = 512,
  parameter int HEADER_SIZE    = 32,
  parameter int NUM_ENGINES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    bdge_valid_in,
  input  logic [HEADER_SIZE-1:0]  header_in,
  input  logic [MESSAGE_SIZE-1:0] message_in,
  output logic                    ctrl_ready_out,
  output logic [NUM_ENGINES-1:0]  eng_valid_out,
  output logic [HEADER_SIZE-1:0]  eng_header_out,
  output logic [MESSAGE_SIZE-1:0] eng_message_out,
  input  logic [NUM_ENGINES-1:0]  eng_ready_in,
  input  logic [NUM_ENGINES-1:0]  eng_done_in,
  output logic                    err_illegal_out,
  output logic                    err_timeout_out,
  output logic [NUM_ENGINES-1:0]  busy_out,
  output logic [15:0]             msg_count_out,
  output logic [15:0]             drop_count_out
);

  localparam int IDX_W = 4;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [7:0]             opcode;
  logic                   op_legal;
  logic [IDX_W-1:0]       dec_idx;
  logic [NUM_ENGINES-1:0] dec_sel;
  logic [NUM_ENGINES-1:0] sel;
  logic                   accept;
  logic                   eng_hs;
  logic                   timer_expire;
  logic                   drop_event;
  logic [NUM_ENGINES-1:0] busy_next;

  assign opcode   = eng_header_out[OPCODE_MSB:OPCODE_LSB];
  assign op_legal = (opcode != 8'(OP_NONE)) && ({24'd0, opcode} <= 32'(NUM_ENGINES));
  assign dec_idx  = IDX_W'(opcode - 8'd1);
  assign dec_sel  = NUM_ENGINES'(1) << dec_idx;
  assign sel      = NUM_ENGINES'(1) << idx;

  assign accept     = bdge_valid_in && ctrl_ready_out;
  assign eng_hs     = (state == ST_DISPATCH) && |(eng_valid_out & eng_ready_in);
  assign drop_event = ((state == ST_DECODE) && !op_legal) ||
                      ((state == ST_DISPATCH) && timer_expire && !eng_hs);

  // Done pulses on idle engines fall out naturally; a handshake only ever targets a non-busy engine
  assign busy_next = (busy_out & ~eng_done_in) | (eng_hs ? sel : '0);

  dispatch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .load_in   (state == ST_DECODE),
    .enable_in (state == ST_DISPATCH),
    .expire_out(timer_expire)
  );

  // Per-engine outstanding-frame flags
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) busy_out <= '0;
    else         busy_out <= busy_next;
  end

  // Dispatch counter wraps, drop counter saturates
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      msg_count_out  <= '0;
      drop_count_out <= '0;
    end else begin
      if (eng_hs) msg_count_out <= msg_count_out + 16'd1;
      if (drop_event && (drop_count_out != 16'hFFFF)) drop_count_out <= drop_count_out + 16'd1;
    end
  end

  // Frame sequencing FSM; engine valid is registered against next-cycle busy state
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= ST_IDLE;
      ctrl_ready_out  <= 1'b0;
      eng_valid_out   <= '0;
      eng_header_out  <= '0;
      eng_message_out <= '0;
      idx             <= '0;
      err_illegal_out <= 1'b0;
      err_timeout_out <= 1'b0;
    end else begin
      err_illegal_out <= 1'b0;
      err_timeout_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            eng_header_out  <= header_in;
            eng_message_out <= message_in;
            ctrl_ready_out  <= 1'b0;
            state           <= ST_DECODE;
          end else begin
            ctrl_ready_out  <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (op_legal) begin
            idx           <= dec_idx;
            eng_valid_out <= dec_sel & ~busy_next;
            state         <= ST_DISPATCH;
          end else begin
            err_illegal_out <= 1'b1;
            state           <= ST_DROP;
          end
        end
        ST_DISPATCH: begin
          if (eng_hs) begin
            eng_valid_out <= '0;
            state         <= ST_HOLDOFF;
          end else if (timer_expire) begin
            eng_valid_out   <= '0;
            err_timeout_out <= 1'b1;
            state           <= ST_HOLDOFF;
          end else begin
            eng_valid_out <= sel & ~busy_next;
          end
        end
        ST_DROP: begin
          state <= ST_HOLDOFF;
        end
        ST_HOLDOFF: begin
          ctrl_ready_out <= 1'b1;
          state          <= ST_IDLE;
        end
        default: begin
          eng_valid_out  <= '0;
          ctrl_ready_out <= 1'b0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_dispatch_ctrl.sv
// Scoreboard bench for msg_dispatch_ctrl: stimulus queues expected dispatches
// and error pulses, a negedge monitor pops and compares them.
module tb_msg_dispatch_ctrl;

  localparam int MS = 512;
  localparam int HS = 32;
  localparam int NE = 2;
  localparam int TO = 16;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          bdge_valid_in;
  logic [HS-1:0] header_in;
  logic [MS-1:0] message_in;
  logic          ctrl_ready_out;
  logic [NE-1:0] eng_valid_out;
  logic [HS-1:0] eng_header_out;
  logic [MS-1:0] eng_message_out;
  logic [NE-1:0] eng_ready_in;
  logic [NE-1:0] eng_done_in;
  logic          err_illegal_out;
  logic          err_timeout_out;
  logic [NE-1:0] busy_out;
  logic [15:0]   msg_count_out;
  logic [15:0]   drop_count_out;

  msg_dispatch_ctrl #(
    .MESSAGE_SIZE(MS), .HEADER_SIZE(HS), .NUM_ENGINES(NE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .bdge_valid_in(bdge_valid_in),
    .header_in(header_in), .message_in(message_in), .ctrl_ready_out(ctrl_ready_out),
    .eng_valid_out(eng_valid_out), .eng_header_out(eng_header_out),
    .eng_message_out(eng_message_out), .eng_ready_in(eng_ready_in),
    .eng_done_in(eng_done_in), .err_illegal_out(err_illegal_out),
    .err_timeout_out(err_timeout_out), .busy_out(busy_out),
    .msg_count_out(msg_count_out), .drop_count_out(drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [NE-1:0] sel;
    logic [31:0]   hdr;
    logic [31:0]   msg;
  } disp_t;

  disp_t exp_disp[$];
  int    exp_err[$];     // 1 = illegal opcode, 2 = timeout
  int    checks = 0;
  int    errors = 0;
  int    valid_hi = 0;
  logic  valid_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every engine handshake and error pulse against the scoreboard
  always @(negedge clk_in) begin
    if (rst_in === 1'b1) begin
      if (eng_valid_out != '0) begin
        valid_hi++;
        valid_seen = 1'b1;
      end
      if (|(eng_valid_out & eng_ready_in)) begin
        if (exp_disp.size() == 0) begin
          chk("unexpected_dispatch", {62'd0, eng_valid_out}, 64'd0);
        end else begin
          disp_t e;
          e = exp_disp.pop_front();
          chk("dispatch_sel", {62'd0, eng_valid_out}, {62'd0, e.sel});
          chk("dispatch_hdr_msg", {eng_header_out, eng_message_out[31:0]}, {e.hdr, e.msg});
        end
      end
      if (err_illegal_out || err_timeout_out) begin
        int code;
        code = err_illegal_out ? 1 : 2;
        if (err_illegal_out && err_timeout_out) code = 3;
        if (exp_err.size() == 0) chk("unexpected_error", 64'(code), 64'd0);
        else                     chk("error_kind", 64'(code), 64'(exp_err.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] op, input logic [23:0] tag, input logic [31:0] m, input int hold);
    int n;
    n = 0;
    cyc(1);
    while (!ctrl_ready_out && n < 50) begin
      cyc(1);
      n++;
    end
    if (!ctrl_ready_out) chk("ready_wait_timeout", 64'd0, 64'd1);
    bdge_valid_in = 1'b1;
    header_in     = {tag, op};
    message_in    = {{(MS-32){1'b0}}, m};
    cyc(hold);
    bdge_valid_in = 1'b0;
  endtask

  task automatic push_disp(input logic [NE-1:0] s, input logic [7:0] op, input logic [23:0] tag, input logic [31:0] m);
    disp_t d;
    d.sel = s;
    d.hdr = {tag, op};
    d.msg = m;
    exp_disp.push_back(d);
  endtask

  initial begin
    rst_in        = 1'b0;
    bdge_valid_in = 1'b0;
    header_in     = '0;
    message_in    = '0;
    eng_ready_in  = '0;
    eng_done_in   = '0;

    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_ready",  {63'd0, ctrl_ready_out}, 64'd0);
    chk("rst_valid",  {62'd0, eng_valid_out}, 64'd0);
    chk("rst_busy",   {62'd0, busy_out}, 64'd0);
    chk("rst_counts", {32'd0, msg_count_out, drop_count_out}, 64'd0);
    chk("rst_errs",   {62'd0, err_illegal_out, err_timeout_out}, 64'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;

    // 1: encrypt frame to engine 0, latency and busy
    eng_ready_in = 2'b01;
    push_disp(2'b01, 8'd1, 24'hA5A5A5, 32'h1111_0001);
    send(8'd1, 24'hA5A5A5, 32'h1111_0001, 1);
    @(negedge clk_in);
    chk("lat_decode_cycle", {62'd0, eng_valid_out}, 64'd0);
    @(negedge clk_in);
    chk("lat_dispatch_cycle", {62'd0, eng_valid_out}, 64'h1);
    @(negedge clk_in);
    chk("t1_valid_dropped", {62'd0, eng_valid_out}, 64'd0);
    chk("t1_busy", {62'd0, busy_out}, 64'h1);
    chk("t1_msg_count", {48'd0, msg_count_out}, 64'd1);

    // 2: opcode 0 and opcode 3 are both illegal
    eng_ready_in = 2'b00;
    valid_seen   = 1'b0;
    exp_err.push_back(1);
    exp_err.push_back(1);
    send(8'd0, 24'h000010, 32'h2222_0000, 1);
    send(8'd3, 24'h000011, 32'h2222_0003, 1);
    cyc(6);
    chk("t2_no_valid", {63'd0, valid_seen}, 64'd0);
    chk("t2_drop_count", {48'd0, drop_count_out}, 64'd2);
    chk("t2_msg_count", {48'd0, msg_count_out}, 64'd1);

    // 3: decrypt frame never accepted times out
    valid_hi = 0;
    exp_err.push_back(2);
    send(8'd2, 24'h000020, 32'h3333_0002, 1);
    cyc(24);
    chk("t3_valid_cycles", 64'(valid_hi), 64'(TO));
    chk("t3_drop_count", {48'd0, drop_count_out}, 64'd3);
    chk("t3_busy_kept", {62'd0, busy_out}, 64'h1);

    // 4a: engine 0 busy holds valid low until done
    eng_ready_in = 2'b01;
    push_disp(2'b01, 8'd1, 24'h000040, 32'h4444_0001);
    send(8'd1, 24'h000040, 32'h4444_0001, 1);
    cyc(5);
    @(negedge clk_in);
    chk("t4_held_while_busy", {62'd0, eng_valid_out}, 64'd0);
    cyc(1);
    eng_done_in = 2'b01;
    cyc(1);
    eng_done_in = 2'b00;
    cyc(3);
    chk("t4_msg_count", {48'd0, msg_count_out}, 64'd2);
    chk("t4_busy", {62'd0, busy_out}, 64'h1);

    // 4b: done on engine 0 in the same cycle as handshake on engine 1
    eng_ready_in = 2'b10;
    push_disp(2'b10, 8'd2, 24'h000041, 32'h4444_0002);
    send(8'd2, 24'h000041, 32'h4444_0002, 1);
    cyc(1);
    eng_done_in = 2'b01;
    cyc(1);
    eng_done_in = 2'b00;
    cyc(2);
    chk("t4b_busy", {62'd0, busy_out}, 64'h2);
    chk("t4b_msg_count", {48'd0, msg_count_out}, 64'd3);

    // 5: bridge holds valid an extra cycle -> one dispatch only
    eng_ready_in = 2'b01;
    push_disp(2'b01, 8'd1, 24'h000050, 32'h5555_0001);
    send(8'd1, 24'h000050, 32'h5555_0001, 2);
    cyc(6);
    chk("t5_msg_count", {48'd0, msg_count_out}, 64'd4);
    chk("t5_busy", {62'd0, busy_out}, 64'h3);

    // 5b: reset while a frame is in DISPATCH
    eng_done_in = 2'b11;
    cyc(1);
    eng_done_in  = 2'b00;
    eng_ready_in = 2'b00;
    send(8'd2, 24'h000051, 32'h5555_0002, 1);
    cyc(3);
    @(negedge clk_in);
    chk("t5_pre_reset_valid", {62'd0, eng_valid_out}, 64'h2);
    rst_in = 1'b0;
    #1;
    chk("mid_rst_valid", {62'd0, eng_valid_out}, 64'd0);
    chk("mid_rst_ready_busy", {61'd0, ctrl_ready_out, busy_out}, 64'd0);
    chk("mid_rst_counts", {32'd0, msg_count_out, drop_count_out}, 64'd0);
    chk("mid_rst_header", {32'd0, eng_header_out}, 64'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    cyc(5);
    chk("post_rst_ready", {63'd0, ctrl_ready_out}, 64'd1);
    chk("post_rst_counts", {32'd0, msg_count_out, drop_count_out}, 64'd0);
    chk("scoreboard_drained", 64'(exp_disp.size() + exp_err.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
